inv_sub_bytes_seq: RTL and testbench

- Sequential inverse-SubBytes stage for the AES decryption datapath. It is the inverse of the forward SubBytes layer.
- Accepts a 128-bit state word and applies the AES inverse S-box to all 16 bytes, LANES bytes per clock, through a small bank of inverse S-box lookups.
- Valid/ready handshake on both sides, so it sits between the inverse ShiftRows and AddRoundKey stages of the decryption round pipeline.
- Trades area (LANES lookups instead of 16) for latency.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/inv_sbox_lookup.sv | 11 +
 rtl/inv_sub_bytes_seq.sv | 125 ++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: state/byte widths, the round-stage FSM state type,
// and the forward and inverse S-box tables (index = input byte).
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/inv_sbox_lookup.sv
// One inverse S-box lookup: purely combinational byte substitution.
module inv_sbox_lookup
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] din,
  output logic [AES_BYTE_W-1:0] dout
);

  assign dout = inv_sbox(din);

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential inverse SubBytes: substitutes the 16 state bytes LANES at a time
// in a working register, then presents the whole word downstream.
//
// Handshake (both sides): a word moves on a rising clock edge where the
// sender's valid and the receiver's ready are both high. The sender holds its
// word and valid steady until that edge; the receiver samples only on it.
// The output side holds isb_out and out_valid stable until out_ready.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4  // 1, 2, 4, 8 or 16; must divide 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] sb_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] isb_out,
  output logic                   busy,
  output state_e                 state_dbg
);

  localparam int NBYTES = AES_STATE_W / AES_BYTE_W;
  localparam int NSTEPS = NBYTES / LANES;
  localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam int OFF_W  = $clog2(AES_STATE_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEPS - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       step_q, step_d;
  logic [AES_STATE_W-1:0] work_q, work_d, work_upd;
  logic                   accept;

  logic [AES_BYTE_W-1:0]  lane_in  [LANES];
  logic [AES_BYTE_W-1:0]  lane_out [LANES];

  // Route the LANES bytes selected by the step counter into the lookups.
  always_comb begin
    logic [OFF_W-1:0] off;
    off = '0;
    for (int l = 0; l < LANES; l++) begin
      off        = OFF_W'((int'(step_q) * LANES + l) * AES_BYTE_W);
      lane_in[l] = work_q[off +: AES_BYTE_W];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_sbox_lookup u_lookup (
      .din  (lane_in[g]),
      .dout (lane_out[g])
    );
  end

  // Working register with the current step's bytes replaced in place.
  always_comb begin
    logic [OFF_W-1:0] off;
    off      = '0;
    work_upd = work_q;
    for (int l = 0; l < LANES; l++) begin
      off                           = OFF_W'((int'(step_q) * LANES + l) * AES_BYTE_W);
      work_upd[off +: AES_BYTE_W]   = lane_out[l];
    end
  end

  // A new word can enter from IDLE, or from DONE in the same cycle the
  // finished word leaves.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state, counter and working-register update.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          step_d  = '0;
          work_d  = sb_in;
        end
      end
      RUN: begin
        work_d = work_upd;
        if (step_q == LAST_STEP) begin
          state_d = DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        if (accept) begin
          state_d = RUN;
          step_d  = '0;
          work_d  = sb_in;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and working register; reset discards any block in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      work_q  <= work_d;
    end
  end

  // Only a finished word is ever visible on isb_out.
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign isb_out   = (state_q == DONE) ? work_q : '0;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: directed vector table, latency sweep over
// LANES, backpressure, back-to-back round trips and reset-abort sequences.
module tb_inv_sub_bytes_seq;
  import aes_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (LANES = 4) ----------------
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] sb_in, isb_out;
  state_e       state_dbg;

  inv_sub_bytes_seq #(.LANES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sb_in(sb_in), .out_valid(out_valid), .out_ready(out_ready),
    .isb_out(isb_out), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- sweep DUTs (LANES = 1, 2, 16) ----------------
  logic         sw_valid;
  logic         sw_in_ready [3];
  logic         sw_out_valid [3];
  logic         sw_busy [3];
  logic [127:0] sw_out [3];
  state_e       sw_state [3];

  inv_sub_bytes_seq #(.LANES(1)) dut_l1 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(sw_in_ready[0]),
    .sb_in(sb_in), .out_valid(sw_out_valid[0]), .out_ready(1'b1),
    .isb_out(sw_out[0]), .busy(sw_busy[0]), .state_dbg(sw_state[0])
  );
  inv_sub_bytes_seq #(.LANES(2)) dut_l2 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(sw_in_ready[1]),
    .sb_in(sb_in), .out_valid(sw_out_valid[1]), .out_ready(1'b1),
    .isb_out(sw_out[1]), .busy(sw_busy[1]), .state_dbg(sw_state[1])
  );
  inv_sub_bytes_seq #(.LANES(16)) dut_l16 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(sw_in_ready[2]),
    .sb_in(sb_in), .out_valid(sw_out_valid[2]), .out_ready(1'b1),
    .isb_out(sw_out[2]), .busy(sw_busy[2]), .state_dbg(sw_state[2])
  );

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q[$];
  int           acc_cyc;

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  // Output transfers happen on the next rising edge; look at them mid-cycle.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("scoreboard_unexpected_output");
      end else begin
        check128("scoreboard", isb_out, exp_q.pop_front());
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] fwd_sub(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(x[8*i +: 8]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present w, wait for in_ready, transfer on the next edge; e is the
  // expected result. Scrambles sb_in afterwards to prove single sampling.
  task automatic send(input logic [127:0] w, input logic [127:0] e);
    int n;
    n = 0;
    sb_in    = w;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      fail_now("send_in_ready");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    sb_in    = rand128();
  endtask

  task automatic wait_out(output logic [127:0] got);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) fail_now("wait_out_valid");
    got = isb_out;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [7];

  // ---------------- main sequence ----------------
  initial begin
    int           lat [4];
    logic [127:0] lat_out [4];
    logic [127:0] got, a, b, x, y, w;
    int           prev_acc, n;

    vecs[0] = '{din: {16{8'h63}},                             exp: 128'h0};
    vecs[1] = '{din: {4{32'h16ed7c00}},                       exp: {4{32'hff530152}}};
    vecs[2] = '{din: 128'h0,                                  exp: {16{8'h52}}};
    vecs[3] = '{din: {16{8'hff}},                             exp: {16{8'h7d}}};
    vecs[4] = '{din: 128'h0f0e0d0c0b0a09080706050403020100,   exp: 128'hfbd7f3819ea340bf38a53630d56a0952};
    vecs[5] = '{din: {16{8'h52}},                             exp: {16{8'h48}}};
    vecs[6] = '{din: {4{32'hca8c0153}},                       exp: {4{32'h10f00950}}};

    cyc       = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    sw_valid  = 1'b0;
    out_ready = 1'b0;
    sb_in     = '0;

    // Reset state
    #13;
    check_int("rst_out_valid", int'(out_valid), 0);
    check_int("rst_busy", int'(busy), 0);
    check128("rst_isb_out", isb_out, 128'h0);
    check_int("rst_state_idle", int'(state_dbg == IDLE), 1);
    #10;
    reset = 1'b0;
    #1;
    check_int("idle_in_ready", int'(in_ready), 1);
    tick();

    // 0x63 vector into every LANES variant; measure latency in edges,
    // counting the acceptance edge as edge 1.
    sb_in    = {16{8'h63}};
    in_valid = 1'b1;
    sw_valid = 1'b1;
    exp_q.push_back(128'h0);
    for (int i = 0; i < 4; i++) begin
      lat[i]     = 0;
      lat_out[i] = '1;
    end
    tick();
    in_valid = 1'b0;
    sw_valid = 1'b0;
    check_int("accept_busy", int'(busy), 1);
    for (int e = 2; e <= 20; e++) begin
      tick();
      if (out_valid && lat[0] == 0) begin lat[0] = e; lat_out[0] = isb_out; end
      for (int k = 0; k < 3; k++) begin
        if (sw_out_valid[k] && lat[k+1] == 0) begin lat[k+1] = e; lat_out[k+1] = sw_out[k]; end
      end
    end
    check_int("latency_lanes4", lat[0], 5);
    check_int("latency_lanes1", lat[1], 17);
    check_int("latency_lanes2", lat[2], 9);
    check_int("latency_lanes16", lat[3], 2);
    for (int k = 0; k < 4; k++) check128("sweep_result", lat_out[k], 128'h0);
    out_ready = 1'b1;
    tick();

    // Directed vector table
    foreach (vecs[i]) begin
      send(vecs[i].din, vecs[i].exp);
      wait_out(got);
      check128("vector", got, vecs[i].exp);
    end
    tick();
    tick();

    // Backpressure: result held, second word refused until release
    out_ready = 1'b0;
    a = rand128();
    b = rand128();
    send(fwd_sub(a), a);
    wait_out(got);
    sb_in    = fwd_sub(b);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check128("bp_hold_data", isb_out, a);
      check_int("bp_hold_flags", int'({out_valid, in_ready, busy}), 3'b100);
    end
    out_ready = 1'b1;
    #1;
    check_int("bp_release_in_ready", int'(in_ready), 1);
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb_in    = rand128();
    check_int("bp_second_accepted", int'(busy), 1);
    wait_out(got);
    check128("bp_second_result", got, b);
    tick();

    // Back-to-back round trips: in_valid kept high, one block per 5 cycles
    prev_acc = 0;
    for (int k = 0; k < 1000; k++) begin
      w = rand128();
      send(fwd_sub(w), w);
      in_valid = 1'b1;
      if (k > 0) check_int("b2b_interval", acc_cyc - prev_acc, 5);
      prev_acc = acc_cyc;
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_int("b2b_drained", exp_q.size(), 0);

    // Reset at step 2 of RUN aborts silently
    x = rand128();
    send(fwd_sub(x), x);
    tick();
    tick();
    check_int("abort_busy_before", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check_int("abort_out_valid", int'(out_valid), 0);
    check_int("abort_busy", int'(busy), 0);
    check128("abort_isb_out", isb_out, 128'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    tick();
    y = rand128();
    send(fwd_sub(y), y);
    wait_out(got);
    check128("after_abort_result", got, y);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_int("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
